// File: rtl/hex_display_avm_writer.sv
// Avalon-MM master that writes a 16-bit value to a HEX3..HEX0 PIO as four active-low 7-segment bytes.
// Latency: avm_write is asserted the cycle after a value is accepted; shown_value updates the cycle after the write completes.
// Backpressure: one pending slot (value_ready = !slot_full); bus outputs stay stable while avm_waitrequest is high.
// Optional feature: define HEX_READBACK_EN to read the register back after each write and flag a sticky err on mismatch.
module hex_display_avm_writer #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          ADDR_W        = 32,
    parameter int          BLANK_LEADING = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       value,
    input  logic              value_valid,
    output logic              value_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic [15:0]       shown_value,
    output logic              err,
    input  logic              err_clr
);

`ifdef HEX_READBACK_EN
    typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_t;
`else
    typedef enum logic {IDLE, WRITE} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] cur_q, cur_d;
    logic [15:0] pend_val_q, pend_val_d;
    logic        pend_full_q, pend_full_d;
    logic [15:0] shown_q, shown_d;
    logic        accept;

    // Active-low segments, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // Byte k carries digit k; a digit is blanked only if it and every higher digit are zero (digit 0 never).
    function automatic logic [31:0] encode(input logic [15:0] v);
        logic [3:0] blank;
        blank[3] = (BLANK_LEADING != 0) && (v[15:12] == 4'h0);
        blank[2] = blank[3] && (v[11:8] == 4'h0);
        blank[1] = blank[2] && (v[7:4] == 4'h0);
        blank[0] = 1'b0;
        encode = '0;
        for (int k = 0; k < 4; k++) begin
            encode[8*k +: 8] = blank[k] ? 8'h7F : {1'b0, seg7(v[4*k +: 4])};
        end
    endfunction

    assign accept         = value_valid && !pend_full_q;
    assign value_ready    = !pend_full_q;
    assign avm_address    = ADDR_W'(BASE_ADDR);
    assign avm_byteenable = 4'hF;
    assign avm_write      = (state_q == WRITE);
    assign avm_writedata  = wdata_q;
    assign busy           = (state_q != IDLE) || pend_full_q;
    assign shown_value    = shown_q;

`ifdef HEX_READBACK_EN
    logic err_q, err_d;
    logic mismatch;
    assign avm_read = (state_q == READ);
    assign err      = err_q;
`else
    wire unused_readback = ^{avm_readdata, avm_readdatavalid, err_clr};
    assign avm_read = 1'b0;
    assign err      = 1'b0;
`endif

    // Next-state: transaction sequencing, pending-slot management and word encoding.
    always_comb begin
        state_d     = state_q;
        wdata_d     = wdata_q;
        cur_d       = cur_q;
        pend_val_d  = pend_val_q;
        pend_full_d = pend_full_q;
        shown_d     = shown_q;
`ifdef HEX_READBACK_EN
        mismatch    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pend_full_q) begin
                    cur_d       = pend_val_q;
                    wdata_d     = encode(pend_val_q);
                    pend_full_d = 1'b0;
                    state_d     = WRITE;
                end else if (accept) begin
                    cur_d   = value;
                    wdata_d = encode(value);
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    shown_d = cur_q;
`ifdef HEX_READBACK_EN
                    state_d = READ;
`else
                    if (pend_full_q) begin
                        cur_d       = pend_val_q;
                        wdata_d     = encode(pend_val_q);
                        pend_full_d = 1'b0;
                        state_d     = WRITE;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef HEX_READBACK_EN
            READ: begin
                if (!avm_waitrequest) state_d = RWAIT;
            end
            RWAIT: begin
                if (avm_readdatavalid) begin
                    mismatch = (avm_readdata != wdata_q);
                    if (pend_full_q) begin
                        cur_d       = pend_val_q;
                        wdata_d     = encode(pend_val_q);
                        pend_full_d = 1'b0;
                        state_d     = WRITE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // A value not started directly lands in the slot; the slot is empty whenever accept is possible.
        if (accept && (state_q != IDLE)) begin
            pend_val_d  = value;
            pend_full_d = 1'b1;
        end
`ifdef HEX_READBACK_EN
        err_d = (err_q && !err_clr) || mismatch;
`endif
    end

    // State registers; async reset drops bus requests and discards any pending value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wdata_q     <= 32'h4040_4040;
            cur_q       <= '0;
            pend_val_q  <= '0;
            pend_full_q <= 1'b0;
            shown_q     <= '0;
`ifdef HEX_READBACK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wdata_q     <= wdata_d;
            cur_q       <= cur_d;
            pend_val_q  <= pend_val_d;
            pend_full_q <= pend_full_d;
            shown_q     <= shown_d;
`ifdef HEX_READBACK_EN
            err_q       <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_hex_display_avm_writer.sv
// Directed bench for hex_display_avm_writer with a small Avalon slave model.
// Uses BLANK_LEADING=1 and a non-zero base address; readback checks compile in with HEX_READBACK_EN.
// Inputs are driven on the falling edge and outputs sampled there.
module tb_hex_display_avm_writer;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk, reset_n;
    logic [15:0] value;
    logic        value_valid, value_ready;
    logic [31:0] avm_address;
    logic        avm_write, avm_read;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] rd_data;
    logic        rdv;
    logic        busy;
    logic [15:0] shown_value;
    logic        err, err_clr;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wr_seen = 0;
    logic [31:0] log_data [0:63];
    logic [31:0] log_addr [0:63];
    logic [3:0]  log_be   [0:63];
    logic [31:0] last_wr;
    logic        bad_rd;

    hex_display_avm_writer #(.BASE_ADDR(BASE), .ADDR_W(32), .BLANK_LEADING(1)) dut (
        .clk(clk), .reset_n(reset_n), .value(value), .value_valid(value_valid),
        .value_ready(value_ready), .avm_address(avm_address), .avm_write(avm_write),
        .avm_read(avm_read), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(rd_data), .avm_readdatavalid(rdv),
        .busy(busy), .shown_value(shown_value), .err(err), .err_clr(err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model: logs completed writes, answers reads one cycle later.
    always @(posedge clk) begin
        rdv <= 1'b0;
        if (avm_write && !avm_waitrequest) begin
            log_data[wr_cnt & 63] <= avm_writedata;
            log_addr[wr_cnt & 63] <= avm_address;
            log_be[wr_cnt & 63]   <= avm_byteenable;
            last_wr <= avm_writedata;
            wr_cnt  <= wr_cnt + 1;
        end
        if (avm_read && !avm_waitrequest) begin
            rdv     <= 1'b1;
            rd_data <= bad_rd ? 32'h0 : last_wr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] v);
        logic got;
        got = 1'b0;
        value = v;
        value_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            got = value_ready;
            @(posedge clk);
            @(negedge clk);
            if (got) break;
        end
        value_valid = 1'b0;
        chk("send_accepted", {31'b0, got}, 32'd1);
    endtask

    task automatic expect_write(input string name, input logic [31:0] exp);
        for (int k = 0; k < 100; k++) begin
            if (wr_cnt > wr_seen) break;
            @(negedge clk);
        end
        chk({name, "_seen"}, {31'b0, wr_cnt > wr_seen}, 32'd1);
        if (wr_cnt > wr_seen) begin
            chk({name, "_data"}, log_data[wr_seen & 63], exp);
            chk({name, "_addr"}, log_addr[wr_seen & 63], BASE);
            chk({name, "_be"}, {28'b0, log_be[wr_seen & 63]}, 32'hF);
            wr_seen++;
        end
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 100; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk({name, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [15:0] v;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{16'h1234, 32'h7924_3019};
        vecs[1] = '{16'hABCD, 32'h0803_4621};
        vecs[2] = '{16'h0000, 32'h7F7F_7F40};
        vecs[3] = '{16'h0007, 32'h7F7F_7F78};
        vecs[4] = '{16'hFFFF, 32'h0E0E_0E0E};
        vecs[5] = '{16'h0010, 32'h7F7F_7940};
        vecs[6] = '{16'h0100, 32'h7F79_4040};
        vecs[7] = '{16'h8000, 32'h0040_4040};
        vecs[8] = '{16'h6789, 32'h0278_0010};

        reset_n = 1'b0; value = '0; value_valid = 1'b0;
        avm_waitrequest = 1'b0; err_clr = 1'b0; bad_rd = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wdata", avm_writedata, 32'h4040_4040);
        chk("rst_write", {31'b0, avm_write}, 0);
        chk("rst_read", {31'b0, avm_read}, 0);
        chk("rst_ready", {31'b0, value_ready}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_shown", {16'b0, shown_value}, 0);
        chk("rst_err", {31'b0, err}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single writes with no stall, one per table entry.
        foreach (vecs[i]) begin
            send(vecs[i].v);
            expect_write($sformatf("vec%0d", i), vecs[i].exp_wdata);
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_shown", i), {16'b0, shown_value}, {16'b0, vecs[i].v});
            chk($sformatf("vec%0d_err", i), {31'b0, err}, 0);
        end

        // Stalled write with a second value parked in the pending slot.
        avm_waitrequest = 1'b1;
        send(16'hABCD);
        chk("stall_write_up", {31'b0, avm_write}, 1);
        send(16'h0007);
        chk("stall_ready_low", {31'b0, value_ready}, 0);
        chk("stall_busy", {31'b0, busy}, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_write", c), {31'b0, avm_write}, 1);
            chk($sformatf("stall%0d_data", c), avm_writedata, 32'h0803_4621);
            chk($sformatf("stall%0d_addr", c), avm_address, BASE);
        end
        avm_waitrequest = 1'b0;
        expect_write("b2b_first", 32'h0803_4621);
        chk("b2b_shown_first", {16'b0, shown_value}, 32'h0000_ABCD);
        chk("b2b_ready_back", {31'b0, value_ready}, 1);
`ifndef HEX_READBACK_EN
        chk("b2b_write_held", {31'b0, avm_write}, 1);
        chk("b2b_data_next", avm_writedata, 32'h7F7F_7F78);
`endif
        expect_write("b2b_second", 32'h7F7F_7F78);
        wait_idle("b2b");
        chk("b2b_shown_second", {16'b0, shown_value}, 32'h0000_0007);

        // Async reset mid-transfer with a pending value.
        avm_waitrequest = 1'b1;
        send(16'h1111);
        send(16'h2222);
        chk("rst_mid_busy", {31'b0, busy}, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_write", {31'b0, avm_write}, 0);
        chk("rst_mid_ready", {31'b0, value_ready}, 1);
        chk("rst_mid_shown", {16'b0, shown_value}, 0);
        chk("rst_mid_wdata", avm_writedata, 32'h4040_4040);
        @(negedge clk);
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_no_write", wr_cnt, wr_seen);
        chk("rst_mid_write_low", {31'b0, avm_write}, 0);
        chk("rst_mid_idle", {31'b0, busy}, 0);

`ifdef HEX_READBACK_EN
        // Readback mismatch sets a sticky err; err_clr clears it.
        bad_rd = 1'b1;
        send(16'hFFFF);
        expect_write("rb_bad", 32'h0E0E_0E0E);
        wait_idle("rb_bad");
        chk("rb_err_set", {31'b0, err}, 1);
        chk("rb_shown", {16'b0, shown_value}, 32'h0000_FFFF);
        repeat (3) @(negedge clk);
        chk("rb_err_sticky", {31'b0, err}, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("rb_err_clr", {31'b0, err}, 0);
        bad_rd = 1'b0;
        send(16'h1234);
        expect_write("rb_good", 32'h7924_3019);
        wait_idle("rb_good");
        chk("rb_err_stays", {31'b0, err}, 0);
`else
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("norb_err", {31'b0, err}, 0);
        chk("norb_read", {31'b0, avm_read}, 0);
`endif

        repeat (5) @(negedge clk);
        chk("no_extra_writes", wr_cnt, wr_seen);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
